// File: rtl/iob_ddr_bringup_ctrl.sv
// DDR3 EMIF bring-up sequencer: pulses EMIF reset, qualifies PLL lock, bounds calibration,
// retries on failure and holds the SoC in reset until the memory path is usable.
module iob_ddr_bringup_ctrl #(
    parameter int EMIF_RST_CYC    = 16,
    parameter int LOCK_STABLE_CYC = 256,
    parameter int CAL_TIMEOUT_CYC = 1048576,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_W           = 24,
    parameter int RETRY_W         = 4
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               pll_locked_i,
    input  logic               init_done_i,
    input  logic               cal_success_i,
    input  logic               cal_fail_i,
    output logic               emif_rst_o,
    output logic               sys_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retries_o
);

    // state       | meaning
    // S_EMIF_RST  | EMIF held in reset for EMIF_RST_CYC cycles
    // S_WAIT_LOCK | waiting for LOCK_STABLE_CYC consecutive cycles of PLL lock
    // S_WAIT_CAL  | waiting for init_done & cal_success, bounded by CAL_TIMEOUT_CYC
    // S_RUN       | memory usable, SoC released from reset
    // S_FAIL      | retries exhausted, terminal until arst_i
    typedef enum logic [2:0] {
        S_EMIF_RST,
        S_WAIT_LOCK,
        S_WAIT_CAL,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] EMIF_LAST = CNT_W'(EMIF_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retries;
    logic [RETRY_W-1:0] w_retries_nxt;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic               w_locked_s;
    logic               w_init_done_s;
    logic               w_cal_success_s;
    logic               w_cal_fail_s;
    logic               w_error;
    logic               w_can_retry;
    logic [RETRY_W-1:0] w_retries_inc;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {cal_fail_i, cal_success_i, init_done_i, pll_locked_i};
            r_sync2 <= r_sync1;
        end
    end

    assign w_locked_s      = r_sync2[0];
    assign w_init_done_s   = r_sync2[1];
    assign w_cal_success_s = r_sync2[2];
    assign w_cal_fail_s    = r_sync2[3];

    // Retry count keeps counting attempts against MAX_RETRY but never wraps.
    assign w_can_retry   = 32'(r_retries) < 32'(MAX_RETRY);
    assign w_retries_inc = (r_retries == '1) ? r_retries : r_retries + RETRY_W'(1);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state   <= S_EMIF_RST;
            r_cnt     <= '0;
            r_retries <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retries <= w_retries_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_error       = 1'b0;
        case (r_state)
            S_EMIF_RST: begin
                if (r_cnt == EMIF_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (!w_locked_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = S_WAIT_CAL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_CAL: begin
                // Failure, lock loss and timeout all beat a same-cycle success.
                if (w_cal_fail_s || !w_locked_s || (r_cnt == CAL_LAST)) begin
                    w_error = 1'b1;
                end else if (w_init_done_s && w_cal_success_s) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!w_locked_s || !w_init_done_s) begin
                    w_error = 1'b1;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_FAIL;
            end
        endcase

        if (w_error) begin
            w_cnt_nxt = '0;
            if (w_can_retry) begin
                w_state_nxt   = S_EMIF_RST;
                w_retries_nxt = w_retries_inc;
            end else begin
                w_state_nxt = S_FAIL;
            end
        end
    end

    assign emif_rst_o = (r_state == S_EMIF_RST) || (r_state == S_FAIL);
    assign sys_rst_o  = (r_state != S_RUN);
    assign ready_o    = (r_state == S_RUN);
    assign fail_o     = (r_state == S_FAIL);
    assign retries_o  = r_retries;

endmodule

// File: tb/tb_iob_ddr_bringup_ctrl.sv
// Bench for iob_ddr_bringup_ctrl: per-cycle input plans, a phase-level reference model that
// predicts every output change, and a monitor that checks each change against the queue.
module tb_iob_ddr_bringup_ctrl;

    localparam int E    = 4;
    localparam int L    = 8;
    localparam int T    = 32;
    localparam int M    = 2;
    localparam int CW   = 8;
    localparam int RW   = 4;
    localparam int HMAX = 400;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          pll_locked = 1'b0;
    logic          init_done = 1'b0;
    logic          cal_success = 1'b0;
    logic          cal_fail = 1'b0;
    logic          emif_rst;
    logic          sys_rst;
    logic          ready;
    logic          fail;
    logic [RW-1:0] retries;

    iob_ddr_bringup_ctrl #(
        .EMIF_RST_CYC   (E),
        .LOCK_STABLE_CYC(L),
        .CAL_TIMEOUT_CYC(T),
        .MAX_RETRY      (M),
        .CNT_W          (CW),
        .RETRY_W        (RW)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .pll_locked_i (pll_locked),
        .init_done_i  (init_done),
        .cal_success_i(cal_success),
        .cal_fail_i   (cal_fail),
        .emif_rst_o   (emif_rst),
        .sys_rst_o    (sys_rst),
        .ready_o      (ready),
        .fail_o       (fail),
        .retries_o    (retries)
    );

    always #5 clk = ~clk;

    // vec = {emif_rst, sys_rst, ready, fail, retries}
    typedef struct {
        int         edge_n;
        logic [7:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    string      scn = "por";
    bit         lk[0:HMAX];
    bit         id[0:HMAX];
    bit         cs[0:HMAX];
    bit         cf[0:HMAX];
    logic [7:0] cur;

    assign cur = {emif_rst, sys_rst, ready, fail, retries};

    // Synchronized value the controller acts on at edge e: input level after edge e-3.
    function automatic bit lock_s(input int e);
        return (e >= 3) ? lk[e-3] : 1'b0;
    endfunction
    function automatic bit init_s(input int e);
        return (e >= 3) ? id[e-3] : 1'b0;
    endfunction
    function automatic bit succ_s(input int e);
        return (e >= 3) ? cs[e-3] : 1'b0;
    endfunction
    function automatic bit cfail_s(input int e);
        return (e >= 3) ? cf[e-3] : 1'b0;
    endfunction

    task automatic push(input int e, input bit em, input bit sy, input bit rd, input bit fl,
                        input int rt);
        ev_t ev;
        ev.edge_n = e;
        ev.vec    = {em, sy, rd, fl, 4'(rt)};
        exp_q.push_back(ev);
    endtask

    // Walks bring-up attempts phase by phase and records when each output change is due.
    task automatic build_expect(input int h);
        int s, w, c, r, x, rt;
        bit ok;
        s  = 0;
        rt = 0;
        forever begin
            w = s + E;
            if (w > h) break;
            push(w, 1'b0, 1'b1, 1'b0, 1'b0, rt);
            c = -1;
            for (int e = w + L; e <= h && c < 0; e++) begin
                ok = 1'b1;
                for (int k = 0; k < L; k++) if (!lock_s(e - k)) ok = 1'b0;
                if (ok) c = e;
            end
            if (c < 0) break;
            x = -1;
            r = -1;
            for (int e = c + 1; e <= h && x < 0 && r < 0; e++) begin
                if (cfail_s(e) || !lock_s(e) || e == c + T) x = e;
                else if (init_s(e) && succ_s(e)) r = e;
            end
            if (r >= 0) begin
                push(r, 1'b0, 1'b0, 1'b1, 1'b0, rt);
                for (int e = r + 1; e <= h && x < 0; e++)
                    if (!lock_s(e) || !init_s(e)) x = e;
            end
            if (x < 0) break;
            if (rt < M) begin
                rt++;
                push(x, 1'b1, 1'b1, 1'b0, 1'b0, rt);
                s = x;
            end else begin
                push(x, 1'b1, 1'b1, 1'b0, 1'b1, rt);
                break;
            end
        end
    endtask

    task automatic monitor();
        logic [7:0] prev;
        bit         armed;
        ev_t        ev;
        prev  = '0;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                armed = 1'b0;
            end else if (!armed) begin
                prev  = cur;
                armed = 1'b1;
            end else if (cur != prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected_change edge %0d: got %b, required unchanged %b",
                             scn, cyc, cur, prev);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.edge_n != cyc || ev.vec != cur) begin
                        n_fail++;
                        $display("FAIL %s event: got %b at edge %0d, required %b at edge %0d",
                                 scn, cur, cyc, ev.vec, ev.edge_n);
                    end
                end
                prev = cur;
            end
        end
    endtask

    task automatic drive(input int n);
        pll_locked  = lk[n];
        init_done   = id[n];
        cal_success = cs[n];
        cal_fail    = cf[n];
    endtask

    task automatic clear_plan();
        for (int n = 0; n <= HMAX; n++) begin
            lk[n] = 1'b0;
            id[n] = 1'b0;
            cs[n] = 1'b0;
            cf[n] = 1'b0;
        end
    endtask

    // Assumes arst is high on entry; releases it, runs h edges, then checks all events arrived.
    task automatic run_scn(input string name, input int h);
        scn = name;
        exp_q.delete();
        build_expect(h);
        @(posedge clk);
        #2;
        drive(0);
        arst   = 1'b0;
        cyc    = 0;
        mon_en = 1'b1;
        for (int n = 1; n <= h; n++) begin
            @(posedge clk);
            cyc = n;
            #1 drive(n);
        end
        #6;
        mon_en = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_events: got %0d pending (first %b at edge %0d), required 0",
                     scn, exp_q.size(), exp_q[0].vec, exp_q[0].edge_n);
            exp_q.delete();
        end
    endtask

    // Reset must take effect immediately, with no clock edge in between.
    task automatic check_reset(input string name);
        arst = 1'b1;
        #1;
        n_tests++;
        if (cur !== 8'b1100_0000) begin
            n_fail++;
            $display("FAIL %s async_reset: got %b, required %b", name, cur, 8'b1100_0000);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t, g, d, k;
        fork
            monitor();
        join_none

        #3;
        check_reset("por");

        clear_plan();
        for (int n = 0; n <= HMAX; n++) begin
            lk[n] = 1'b1;
            id[n] = (n >= 20);
            cs[n] = (n >= 20);
        end
        run_scn("normal_20", 40);
        check_reset("rst_in_run");

        t = $urandom_range(5, 30);
        clear_plan();
        for (int n = 0; n <= HMAX; n++) begin
            lk[n] = 1'b1;
            id[n] = (n >= t);
            cs[n] = (n >= t);
        end
        run_scn("normal_rand", 50);
        check_reset("rst_normal_rand");

        g = $urandom_range(3, 7);
        clear_plan();
        for (int n = 0; n <= HMAX; n++) begin
            lk[n] = (n != g);
            id[n] = 1'b1;
            cs[n] = 1'b1;
        end
        run_scn("lock_glitch", 40);
        check_reset("rst_glitch");

        clear_plan();
        for (int n = 0; n <= HMAX; n++) lk[n] = 1'b1;
        run_scn("cal_timeout", 160);
        check_reset("rst_in_fail");

        t = $urandom_range(10, 40);
        clear_plan();
        for (int n = 0; n <= HMAX; n++) lk[n] = 1'b1;
        id[t] = 1'b1;
        cs[t] = 1'b1;
        cf[t] = 1'b1;
        run_scn("fail_and_success", 100);
        check_reset("rst_fail_success");

        d = $urandom_range(16, 30);
        k = $urandom_range(1, 4);
        clear_plan();
        for (int n = 0; n <= HMAX; n++) begin
            lk[n] = 1'b1;
            id[n] = !(n >= d && n < d + k);
            cs[n] = 1'b1;
            cf[n] = (n >= 11 && n < d) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        run_scn("init_loss", 80);
        check_reset("rst_init_loss");

        d = $urandom_range(16, 30);
        clear_plan();
        for (int n = 0; n <= HMAX; n++) begin
            lk[n] = (n != d);
            id[n] = 1'b1;
            cs[n] = 1'b1;
        end
        run_scn("lock_loss", 80);
        check_reset("rst_lock_loss");

        for (int it = 0; it < 4; it++) begin
            bit l, i, s;
            clear_plan();
            l = 1'b1;
            i = 1'b0;
            s = 1'b0;
            for (int n = 0; n <= HMAX; n++) begin
                if ($urandom_range(0, 24) == 0) l = !l;
                if ($urandom_range(0, 14) == 0) i = !i;
                if ($urandom_range(0, 14) == 0) s = !s;
                lk[n] = l;
                id[n] = i;
                cs[n] = s;
                cf[n] = ($urandom_range(0, 39) == 0);
            end
            run_scn($sformatf("random_%0d", it), 150);
            check_reset($sformatf("rst_random_%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_ddr_bringup_ctrl.md
# iob_ddr_bringup_ctrl

Sequences DDR3 external-memory bring-up on the FPGA targets. It pulses the EMIF reset, waits for the EMIF PLL to lock stably, and waits for calibration. It releases the SoC system reset only when the memory path is usable. It replaces the ad-hoc `~resetn | ~locked | ~init_done` reset OR. It adds bounded calibration timeout, automatic retry, runtime-loss detection and a terminal failure state. It sits in the FPGA wrapper between the `alt_ddr3` status/reset pins and the `iob_reset_sync` feeding `iob_soc_sut`.

## Interface
Parameters:
- `EMIF_RST_CYC`, 16: cycles `emif_rst_o` is held high per bring-up attempt (≥1).
- `LOCK_STABLE_CYC`, 256: consecutive cycles of synchronized lock required (≥1).
- `CAL_TIMEOUT_CYC`, 1048576: max cycles in calibration wait before retry (≥1).
- `MAX_RETRY`, 3: retries allowed before terminal failure (0 = first failure is terminal).
- `CNT_W`, 24: width of the shared cycle counter; must hold the largest of the three cycle parameters.
- `RETRY_W`, 4: width of `retries_o`.

Ports:
- `clk_i` in 1: clock. One clock; all state on `clk_i`.
- `arst_i` in 1: reset, asynchronous, active-high.
- `pll_locked_i` in 1: EMIF PLL locked (asynchronous to `clk_i`).
- `init_done_i` in 1: EMIF `local_init_done` (async).
- `cal_success_i` in 1: EMIF `local_cal_success` (async).
- `cal_fail_i` in 1: EMIF `local_cal_fail` (async).
- `emif_rst_o` out 1: reset to EMIF, active-high (wrapper inverts to `reset_reset_n`).
- `sys_rst_o` out 1: SoC reset request, active-high.
- `ready_o` out 1: memory usable.
- `fail_o` out 1: terminal bring-up failure.
- `retries_o` out RETRY_W: retries performed since `arst_i`, saturating.

## Operation
- The four status inputs each pass a 2-flop synchronizer (`*_s`). Synchronizer flops reset to 0.
- Moore FSM. All outputs decode from state and registered counters only, with no input-to-output combinational path.
- States and outputs:
  - EMIF_RST: `emif_rst_o`=1, `sys_rst_o`=1.
  - WAIT_LOCK: `emif_rst_o`=0, `sys_rst_o`=1.
  - WAIT_CAL: `emif_rst_o`=0, `sys_rst_o`=1.
  - RUN: `emif_rst_o`=0, `sys_rst_o`=0, `ready_o`=1.
  - FAIL: `emif_rst_o`=1, `sys_rst_o`=1, `fail_o`=1.
- EMIF_RST: `cnt` increments each cycle. At `cnt==EMIF_RST_CYC-1` go to WAIT_LOCK and clear `cnt`.
- WAIT_LOCK:
  - `pll_locked_s`=0 clears `cnt`; `pll_locked_s`=1 increments it.
  - At `cnt==LOCK_STABLE_CYC-1` with `pll_locked_s`=1, go to WAIT_CAL and clear `cnt`.
  - No timeout in this state.
- WAIT_CAL:
  - Priority 1: `cal_fail_s`=1 or `pll_locked_s`=0 or `cnt==CAL_TIMEOUT_CYC-1` → ERROR.
  - Priority 2: otherwise, `init_done_s`=1 and `cal_success_s`=1 → RUN.
  - Otherwise increment `cnt`.
- RUN: `pll_locked_s`=0 or `init_done_s`=0 → ERROR. `cal_fail_s` is ignored in RUN.
- ERROR (a transition action, not a state):
  - If `retries_o`<MAX_RETRY: increment `retries_o`, clear `cnt`, go to EMIF_RST.
  - Else go to FAIL.
- FAIL is terminal. Only `arst_i` exits it.
- `retries_o` saturates at all-ones if MAX_RETRY ≥ 2^RETRY_W.
- `arst_i` at any point, including mid-RUN, forces the reset state. `sys_rst_o` is high asynchronously with `arst_i`.

## Timing
- Reset values:
  - state=EMIF_RST, `cnt`=0.
  - `emif_rst_o`=1, `sys_rst_o`=1, `ready_o`=0, `fail_o`=0, `retries_o`=0.
- After `arst_i` falls, `emif_rst_o` stays high for exactly EMIF_RST_CYC rising edges.
- Input-to-FSM latency is 2 edges (synchronizer). The state change lands on the 3rd edge after the input changes.
- Minimum reset-release to `sys_rst_o`=0, with lock and cal already valid: EMIF_RST_CYC + LOCK_STABLE_CYC + 1 edges.
- Loss of lock in RUN: `sys_rst_o` rises on the 3rd edge after `pll_locked_i` falls. `emif_rst_o` rises on that same edge.
- Simultaneous success and fail in WAIT_CAL: fail wins.
- Timeout on the same cycle as success: timeout wins.

## Test plan
Directed parameters for all scenarios: EMIF_RST_CYC=4, LOCK_STABLE_CYC=8, CAL_TIMEOUT_CYC=32, MAX_RETRY=2.

1. Normal bring-up:
   - Stimulus: lock high before reset release, `init_done`/`cal_success` high at cycle 20.
   - Required: `emif_rst_o` high for edges 1–4. `sys_rst_o` falls at edge 23. `ready_o`=1, `retries_o`=0.
2. Lock glitch:
   - Stimulus: `pll_locked_i` low for 1 cycle midway through WAIT_LOCK.
   - Required: stable count restarts. WAIT_CAL entry is delayed by the glitch plus 8 cycles. No retry.
3. Calibration timeout:
   - Stimulus: `init_done` never asserts.
   - Required: three EMIF_RST pulses. `retries_o` reads 1 then 2. FAIL is entered on the third timeout with `fail_o`=1, `emif_rst_o`=1, `sys_rst_o`=1, held indefinitely.
4. `cal_fail` with `cal_success` asserted in the same cycle:
   - Required: retry, `retries_o`=1. `ready_o` never asserts.
5. Runtime loss:
   - Stimulus: in RUN, drop `init_done_i`.
   - Required: `sys_rst_o` and `emif_rst_o` rise 3 edges later, `retries_o`=1. Re-bring-up then reaches RUN again.
6. Reset mid-operation:
   - Stimulus: assert `arst_i` in RUN and in FAIL.
   - Required: all outputs return immediately (asynchronously) to reset values and `retries_o`=0. Normal bring-up follows.
